// File: rtl/conv3x3_mac_engine.sv
// Sequential 3x3 convolution over a 4x4 image of 4-bit pixels: one MAC per cycle,
// four windows, one registered 11-bit result per window.
//   state  | meaning
//   S_IDLE | image buffer writable, waiting for START
//   S_MAC  | accumulating tap r_tap of window r_win
//   S_EMIT | result strobe cycle; next window or back to idle
module conv3x3_mac_engine (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        PIX_VALID,
    input  logic [3:0]  PIX_ADDR,
    input  logic [3:0]  PIX_DATA,
    input  logic [35:0] KERNEL,
    input  logic        START,
    output logic        BUSY,
    output logic        OUT_VALID,
    output logic [1:0]  OUT_IDX,
    output logic [10:0] OUT_DATA,
    output logic        DONE
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [3:0]  r_mem [16];
    logic [1:0]  r_win;
    logic [1:0]  r_ki;
    logic [1:0]  r_kj;
    logic [3:0]  r_tap;
    logic [10:0] r_acc;

    logic        r_busy;
    logic        r_out_valid;
    logic [1:0]  r_out_idx;
    logic [10:0] r_out_data;
    logic        r_done;

    logic [1:0]  w_row;
    logic [1:0]  w_col;
    logic [3:0]  w_rd_addr;
    logic [3:0]  w_pix;
    logic [3:0]  w_weight;
    logic [7:0]  w_prod;
    logic [10:0] w_acc_sum;
    logic        w_last_tap;
    logic        w_last_win;

    // Window origin (w[1], w[0]) plus kernel offset (i, j) never exceeds 3.
    assign w_row     = {1'b0, r_win[1]} + r_ki;
    assign w_col     = {1'b0, r_win[0]} + r_kj;
    assign w_rd_addr = {w_row, w_col};
    assign w_pix     = r_mem[w_rd_addr];

    always_comb begin
        w_weight = 4'd0;
        for (int t = 0; t < 9; t++) begin
            if (r_tap == 4'(t)) begin
                w_weight = KERNEL[4*t +: 4];
            end
        end
    end

    assign w_prod     = {4'b0, w_pix} * {4'b0, w_weight};
    assign w_acc_sum  = r_acc + {3'b0, w_prod};
    assign w_last_tap = (r_tap == 4'd8);
    assign w_last_win = (r_win == 2'd3);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_state_nxt = S_MAC;
                end
            end
            S_MAC: begin
                if (w_last_tap) begin
                    w_state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                w_state_nxt = w_last_win ? S_IDLE : S_MAC;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Image buffer is frozen for the whole run; a write in the START cycle still lands.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int a = 0; a < 16; a++) begin
                r_mem[a] <= 4'd0;
            end
        end else if ((r_state == S_IDLE) && PIX_VALID) begin
            r_mem[PIX_ADDR] <= PIX_DATA;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_win       <= 2'd0;
            r_ki        <= 2'd0;
            r_kj        <= 2'd0;
            r_tap       <= 4'd0;
            r_acc       <= 11'd0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_idx   <= 2'd0;
            r_out_data  <= 11'd0;
            r_done      <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_win  <= 2'd0;
                        r_ki   <= 2'd0;
                        r_kj   <= 2'd0;
                        r_tap  <= 4'd0;
                        r_acc  <= 11'd0;
                        r_busy <= 1'b1;
                    end
                end
                S_MAC: begin
                    r_acc <= w_acc_sum;
                    if (w_last_tap) begin
                        // Result is registered here so the strobe lands in the EMIT cycle.
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_acc_sum;
                        r_out_idx   <= r_win;
                        r_done      <= w_last_win;
                    end else begin
                        r_tap <= r_tap + 4'd1;
                        if (r_kj == 2'd2) begin
                            r_kj <= 2'd0;
                            r_ki <= r_ki + 2'd1;
                        end else begin
                            r_kj <= r_kj + 2'd1;
                        end
                    end
                end
                S_EMIT: begin
                    if (w_last_win) begin
                        r_busy <= 1'b0;
                    end else begin
                        r_win <= r_win + 2'd1;
                        r_ki  <= 2'd0;
                        r_kj  <= 2'd0;
                        r_tap <= 4'd0;
                        r_acc <= 11'd0;
                    end
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY      = r_busy;
    assign OUT_VALID = r_out_valid;
    assign OUT_IDX   = r_out_idx;
    assign OUT_DATA  = r_out_data;
    assign DONE      = r_done;

endmodule
